pos_remote_link_arbiter: RTL

Shares one inter-FPGA position link between `NUM_PORTS` external position-ring nodes. Each node's to-remote stream (offset packet, GCID, lifetime) is buffered per port and round-robin arbitrated into a single registered valid/ready stream toward the AXIS packer. Per-port back-pressure returns to the ring nodes. The block emits one terminator flit per phase once all ring nodes are empty and all position caches are dirty.

---
 rtl/pos_remote_link_arbiter.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pos_remote_link_arbiter.sv
// -----------------------------------------------------------------------------
// pos_remote_link_arbiter
//
// Purpose:
//   Shares one inter-FPGA position link between NUM_PORTS position-ring nodes.
//   Each node's to-remote stream {offset packet, GCID, lifetime} is buffered in
//   a per-port FIFO and round-robin arbitrated into one registered valid/ready
//   stream toward the AXIS packer. Once every ring node is drained and every
//   position cache is dirty, a single terminator flit (o_last = 1) is emitted
//   for the phase. The next terminator is possible only after
//   i_all_pos_caches_dirty drops.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_offset_pkt/i_gcid/
//   i_lifetime/i_valid          per-port push data and strobe (flattened)
//   o_back_pressure             per-port stop request (count >= FIFO_DEPTH-2)
//   i_dest_id                   link destination, sampled at each flit load
//   i_all_pos_ring_nodes_empty  all ring nodes drained
//   i_all_pos_caches_dirty      phase complete; deassertion re-arms
//   o_offset_pkt/o_gcid/
//   o_lifetime/o_src_port/
//   o_dest_id/o_last            output flit
//   o_valid/i_ready             output handshake
//   o_overflow                  sticky per-port drop flag
//
// Optional feature (macro POS_ARB_STATS_EN):
//   o_grant_cnt  per-port saturating count of granted flits
//   o_stall_cnt  saturating count of cycles with o_valid && !i_ready
// -----------------------------------------------------------------------------
module pos_remote_link_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_W      = 24,  // OFFSET_PKT_STRUCT_WIDTH
  parameter int GCID_W     = 9,   // 3*GLOBAL_CELL_ID_WIDTH
  parameter int LT_W       = 8,   // NB_CELL_COUNT_WIDTH
  parameter int DEST_W     = 4,   // STREAMING_TDEST_WIDTH
  localparam int SRC_W     = $clog2(NUM_PORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PORTS*PKT_W-1:0]  i_offset_pkt,
  input  logic [NUM_PORTS*GCID_W-1:0] i_gcid,
  input  logic [NUM_PORTS*LT_W-1:0]   i_lifetime,
  input  logic [NUM_PORTS-1:0]     i_valid,
  output logic [NUM_PORTS-1:0]     o_back_pressure,
  input  logic [DEST_W-1:0]        i_dest_id,
  input  logic                     i_all_pos_ring_nodes_empty,
  input  logic                     i_all_pos_caches_dirty,
  output logic [PKT_W-1:0]         o_offset_pkt,
  output logic [GCID_W-1:0]        o_gcid,
  output logic [LT_W-1:0]          o_lifetime,
  output logic [SRC_W-1:0]         o_src_port,
  output logic [DEST_W-1:0]        o_dest_id,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NUM_PORTS-1:0]     o_overflow
`ifdef POS_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]  o_grant_cnt,
  output logic [31:0]              o_stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PKT_W + GCID_W + LT_W;

  typedef enum logic [1:0] {
    ST_ACTIVE,     // normal arbitration
    ST_TERM,       // end condition seen, waiting for a load slot
    ST_TERM_SENT,  // terminator loaded, waiting for its handshake
    ST_DONE        // phase finished, waiting for re-arm
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [NUM_PORTS-1:0]         w_nonempty;
  logic [NUM_PORTS-1:0]         w_pop_vec;
  logic [NUM_PORTS-1:0][EW-1:0] w_head;

  logic [SRC_W-1:0] r_rr_ptr;
  logic             w_sel_vld;
  logic [SRC_W-1:0] w_sel_idx;
  logic             w_load;
  logic             w_grant;
  logic             w_term_load;
  logic             w_end_cond;

  logic [PKT_W-1:0]  r_offset_pkt;
  logic [GCID_W-1:0] r_gcid;
  logic [LT_W-1:0]   r_lifetime;
  logic [SRC_W-1:0]  r_src_port;
  logic [DEST_W-1:0] r_dest_id;
  logic              r_last;
  logic              r_valid;

  // The output register may take a new flit when it is empty or when its
  // current flit leaves this cycle.
  assign w_load = !r_valid || i_ready;

  // Data grants only happen in ACTIVE; this keeps data flits from ever
  // following a loaded terminator until the phase re-arms.
  assign w_grant = w_sel_vld && w_load && (r_state == ST_ACTIVE);

  // ---------------------------------------------------------------------------
  // Per-port FIFOs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_bp;
    logic          r_ov;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = w_grant && (w_sel_idx == SRC_W'(gi));
    // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
    assign w_push = i_valid[gi] && (!w_full || w_pop);

    // Storage has no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {i_offset_pkt[gi*PKT_W +: PKT_W],
                            i_gcid[gi*GCID_W +: GCID_W],
                            i_lifetime[gi*LT_W +: LT_W]};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_bp     <= 1'b0;
        r_ov     <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        // Threshold on the registered count: two entries of slack remain for
        // the ring node's reaction latency.
        r_bp <= (r_count >= CW'(FIFO_DEPTH - 2));
        if (i_valid[gi] && w_full && !w_pop) r_ov <= 1'b1;
      end
    end

    assign w_nonempty[gi]      = (r_count != '0);
    assign w_head[gi]          = r_mem[r_rd_ptr];
    assign w_pop_vec[gi]       = w_pop;
    assign o_back_pressure[gi] = r_bp;
    assign o_overflow[gi]      = r_ov;
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection: first non-empty port after the last granted one
  // ---------------------------------------------------------------------------
  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_PORTS;
      if (!w_sel_vld && w_nonempty[idx[SRC_W-1:0]]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = idx[SRC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= SRC_W'(NUM_PORTS - 1);
    end else if (w_grant) begin
      r_rr_ptr <= w_sel_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase FSM
  // ---------------------------------------------------------------------------
  // Evaluated on registered FIFO counts, so the terminator can only follow the
  // last pop by at least one cycle.
  assign w_end_cond = i_all_pos_ring_nodes_empty && i_all_pos_caches_dirty &&
                      (w_nonempty == '0) && (i_valid == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACTIVE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_term_load  = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (w_end_cond) w_state_next = ST_TERM;
      end
      ST_TERM: begin
        // Losing the end condition wins over a same-cycle load slot; once the
        // terminator is loaded it is committed.
        if (!w_end_cond) begin
          w_state_next = ST_ACTIVE;
        end else if (w_load) begin
          w_term_load  = 1'b1;
          w_state_next = ST_TERM_SENT;
        end
      end
      ST_TERM_SENT: begin
        if (r_valid && i_ready) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!i_all_pos_caches_dirty) w_state_next = ST_ACTIVE;
      end
      default: w_state_next = ST_ACTIVE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset_pkt <= '0;
      r_gcid       <= '0;
      r_lifetime   <= '0;
      r_src_port   <= '0;
      r_dest_id    <= '0;
      r_last       <= 1'b0;
      r_valid      <= 1'b0;
    end else if (w_load) begin
      if (w_grant) begin
        {r_offset_pkt, r_gcid, r_lifetime} <= w_head[w_sel_idx];
        r_src_port <= w_sel_idx;
        r_dest_id  <= i_dest_id;
        r_last     <= 1'b0;
        r_valid    <= 1'b1;
      end else if (w_term_load) begin
        r_offset_pkt <= '0;
        r_gcid       <= '0;
        r_lifetime   <= '0;
        r_src_port   <= '0;
        r_dest_id    <= i_dest_id;
        r_last       <= 1'b1;
        r_valid      <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_offset_pkt = r_offset_pkt;
  assign o_gcid       = r_gcid;
  assign o_lifetime   = r_lifetime;
  assign o_src_port   = r_src_port;
  assign o_dest_id    = r_dest_id;
  assign o_last       = r_last;
  assign o_valid      = r_valid;

`ifdef POS_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics; only rst clears them, never a phase re-arm
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
    logic [31:0] r_gcnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_gcnt <= '0;
      end else if (w_pop_vec[gi] && (r_gcnt != '1)) begin
        r_gcnt <= r_gcnt + 1'b1;
      end
    end
    assign o_grant_cnt[gi*32 +: 32] = r_gcnt;
  end

  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_valid && !i_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
